char_scroll_disp: RTL
=====================

# char_scroll_disp

Parametrised N-digit seven-segment character display with a message buffer. In manual mode, each shift strobe pushes a character code into the display window, newest digit first, and also appends it to the message buffer. In scroll mode, the stored message rotates through the window automatically at a fixed cycle period. The block sits between the push-button/switch front end and the seven-segment pins.

## Interface
- DIGITS, 3: number of displayed digits (≥1).
- DEPTH, 16: message buffer entries (power of two, ≥DIGITS).
- CODE_W, 5: character code width.
- SCROLL_DIV, 50_000_000: clock cycles per scroll step (≥2).
- Clock and reset are fixed: one clock; reset is synchronous and active-high.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = manual, 1 = scroll.
- shift  in  1  level strobe; internally rising-edge detected.
- code  in  CODE_W  character code to push.
- clear  in  1  synchronous clear of the window and the buffer.
- seg  out  7*DIGITS  segments; digit i occupies seg[7*i +: 7], bit order a..g from MSB down, active-high; digit 0 = newest.
- msg_len  out  $clog2(DEPTH+1)  number of stored characters.
- full  out  1  high when msg_len == DEPTH.

## Operation
- Edge detect: shift_edge = shift_s & ~shift_prev. shift_prev resets to 1, so a strobe held high through reset does not count.
- FSM states:
  - MANUAL: entered on reset. MANUAL→SCROLL when mode=1 is sampled.
  - SCROLL: SCROLL→MANUAL when mode=0 is sampled. The state register decides each cycle's behaviour; a mode change takes effect the following cycle.
- MANUAL, on shift_edge:
  - win[0]←code; win[i]←win[i-1].
  - If !full: buf[wr_ptr]←code, wr_ptr++, msg_len++.
  - If full, the window still shifts but the buffer is unchanged.
- SCROLL:
  - shift_edge is ignored.
  - tick_cnt counts 0..SCROLL_DIV-1. When tick_cnt==SCROLL_DIV-1 and msg_len>0: win shifts in buf[rd_ptr]; rd_ptr wraps to 0 after msg_len-1.
  - msg_len==0: the window holds and the counter still runs.
- On entry to SCROLL: tick_cnt←0, rd_ptr←0. The window is unchanged until the first step.
- On leaving SCROLL: the window holds and tick_cnt←0.
- clear (highest priority, either state):
  - every win entry←BLANK.
  - wr_ptr, rd_ptr, msg_len, tick_cnt←0.
  - The state is unchanged and a same-cycle shift_edge is dropped.
- Reset: same as clear, plus state←MANUAL and shift_prev←1.
- Reset output values: seg all zero (every digit BLANK), msg_len=0, full=0.
- Decoder glyphs (seg pattern, bits a..g):
  - codes 0x00–0x0F: hex glyphs.
  - 0x10 'H' = 0110111.
  - 0x11 'L' = 0001110.
  - 0x12 'P' = 1100111.
  - 0x13 '-' = 0000001.
  - 0x1F BLANK = 0000000.
  - all other codes decode as BLANK.
  - Examples: '0' = 1111110, '1' = 0110000, 'A' = 1110111.

## Timing
- The window is registered and the decoders are combinational.
- Manual latency: shift sampled high (after low) at edge n → seg reflects the new code after edge n. That is one cycle, plus 2 cycles with the synchroniser.
- Scroll step: the first step occurs SCROLL_DIV cycles after the SCROLL entry edge, then every SCROLL_DIV cycles.
- msg_len and full update on the same edge as the buffer write.

## Configuration
- CHAR_DISP_SYNC_EN:
  - Defined: shift passes through a 2-flop synchroniser (reset to 1) before edge detection, adding +2 cycles latency.
  - Undefined: shift_s = shift directly (the caller guarantees it is synchronous).

## Structure
- Package char_disp_pkg holds:
  - SEG_W=7 and BLANK=5'h1F.
  - glyph constants and the state enum {MANUAL, SCROLL}.
- Sub-module char_seg_decode (code→7-bit segment pattern), instantiated DIGITS times in a generate loop.

## Test plan
- Reset with shift held high, then release: seg=0, msg_len=0, no shift occurs.
- Manual, DIGITS=3, push 0x01, 0x02, 0x03 → digit0=1111001 ('3'), digit1=1101101 ('2'), digit2=0110000 ('1'), msg_len=3.
- Manual, DEPTH=4, push 5 codes → full=1 after the 4th push. The 5th code appears in digit0 and msg_len stays 4.
- Scroll, SCROLL_DIV=4, buffer holds 0x0A, 0x0B → steps at cycles 4, 8, 12 show A, B, A in digit0 (wrap), and shift pulses are ignored.
- clear asserted in the same cycle as a shift edge → all digits BLANK, msg_len=0, edge lost.
- Mode toggled 1→0 mid-count, then back to 1 → the first step comes SCROLL_DIV cycles after re-entry and starts from buf[0].

Source files
------------

// File: rtl/char_disp_pkg.sv
// rtl/char_disp_pkg.sv - shared constants, glyphs and state type for the character display
package char_disp_pkg;

  localparam int         SEG_W = 7;
  localparam logic [4:0] BLANK = 5'h1F;

  // Segment patterns, bit 6 = a down to bit 0 = g, active-high
  localparam logic [6:0] G_H     = 7'b0110111;
  localparam logic [6:0] G_L     = 7'b0001110;
  localparam logic [6:0] G_P     = 7'b1100111;
  localparam logic [6:0] G_DASH  = 7'b0000001;
  localparam logic [6:0] G_BLANK = 7'b0000000;

  typedef enum logic {MANUAL, SCROLL} state_t;

  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    case (h)
      4'h0: hex_glyph = 7'b1111110;
      4'h1: hex_glyph = 7'b0110000;
      4'h2: hex_glyph = 7'b1101101;
      4'h3: hex_glyph = 7'b1111001;
      4'h4: hex_glyph = 7'b0110011;
      4'h5: hex_glyph = 7'b1011011;
      4'h6: hex_glyph = 7'b1011111;
      4'h7: hex_glyph = 7'b1110000;
      4'h8: hex_glyph = 7'b1111111;
      4'h9: hex_glyph = 7'b1111011;
      4'hA: hex_glyph = 7'b1110111;
      4'hB: hex_glyph = 7'b0011111;
      4'hC: hex_glyph = 7'b1001110;
      4'hD: hex_glyph = 7'b0111101;
      4'hE: hex_glyph = 7'b1001111;
      default: hex_glyph = 7'b1000111;
    endcase
  endfunction

endpackage

// File: rtl/char_seg_decode.sv
// rtl/char_seg_decode.sv - combinational character code to seven-segment pattern
module char_seg_decode
  import char_disp_pkg::*;
#(
  parameter int CODE_W = 5
) (
  input  logic [CODE_W-1:0] code,
  output logic [SEG_W-1:0]  seg
);

  always_comb begin
    seg = G_BLANK;
    if (code < CODE_W'(16))              seg = hex_glyph(code[3:0]);
    else if (code == CODE_W'(5'h10))     seg = G_H;
    else if (code == CODE_W'(5'h11))     seg = G_L;
    else if (code == CODE_W'(5'h12))     seg = G_P;
    else if (code == CODE_W'(5'h13))     seg = G_DASH;
  end

endmodule

// File: rtl/char_scroll_disp.sv
// rtl/char_scroll_disp.sv - N-digit display window with message buffer, manual push and auto scroll; CHAR_DISP_SYNC_EN adds a 2-flop shift synchroniser
module char_scroll_disp
  import char_disp_pkg::*;
#(
  parameter int DIGITS     = 3,
  parameter int DEPTH      = 16,
  parameter int CODE_W     = 5,
  parameter int SCROLL_DIV = 50_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode,
  input  logic                         shift,
  input  logic [CODE_W-1:0]            code,
  input  logic                         clear,
  output logic [SEG_W*DIGITS-1:0]      seg,
  output logic [$clog2(DEPTH+1)-1:0]   msg_len,
  output logic                         full
);

  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LEN_W  = $clog2(DEPTH+1);
  localparam int TICK_W = $clog2(SCROLL_DIV);
  localparam logic [CODE_W-1:0] BLANK_C = CODE_W'(BLANK);

  logic               shift_s, shift_prev, shift_edge;
  state_t             state, state_next;
  logic               push, step, tick_wrap;
  logic [TICK_W-1:0]  tick_cnt;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CODE_W-1:0]  win [DIGITS];
  logic [CODE_W-1:0]  msg_buf [DEPTH];
  logic [CODE_W-1:0]  win_in;

`ifdef CHAR_DISP_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], shift};
  end
  assign shift_s = sync_q[1];
`else
  assign shift_s = shift;
`endif

  // prev resets high so a strobe already held through reset is not an edge
  always_ff @(posedge clk) begin
    if (rst) shift_prev <= 1'b1;
    else     shift_prev <= shift_s;
  end
  assign shift_edge = shift_s & ~shift_prev;

  assign tick_wrap = (tick_cnt == TICK_W'(SCROLL_DIV-1));
  assign full      = (msg_len == LEN_W'(DEPTH));

  always_comb begin
    state_next = state;
    push       = 1'b0;
    step       = 1'b0;
    if (!clear) begin
      case (state)
        MANUAL: begin
          push = shift_edge;
          if (mode) state_next = SCROLL;
        end
        SCROLL: begin
          if (!mode) state_next = MANUAL;
          else       step = tick_wrap && (msg_len != '0);
        end
        default: state_next = MANUAL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MANUAL;
    else     state <= state_next;
  end

  assign win_in = push ? code : msg_buf[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int i = 0; i < DIGITS; i++) win[i] <= BLANK_C;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      msg_len  <= '0;
      tick_cnt <= '0;
    end else begin
      if (push || step) begin
        for (int i = DIGITS-1; i > 0; i--) win[i] <= win[i-1];
        win[0] <= win_in;
      end
      if (push && !full) begin
        wr_ptr  <= wr_ptr + PTR_W'(1);
        msg_len <= msg_len + LEN_W'(1);
      end
      if (state == MANUAL) begin
        tick_cnt <= '0;
        if (mode) rd_ptr <= '0;
      end else if (!mode) begin
        tick_cnt <= '0;
      end else begin
        tick_cnt <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
        if (step) rd_ptr <= (LEN_W'(rd_ptr) == msg_len - LEN_W'(1)) ? '0 : rd_ptr + PTR_W'(1);
      end
    end
  end

  // Storage only; validity is tracked by msg_len so it needs no reset
  always_ff @(posedge clk) begin
    if (!rst && push && !full) msg_buf[wr_ptr] <= code;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    char_seg_decode #(.CODE_W(CODE_W)) u_dec (
      .code (win[g]),
      .seg  (seg[SEG_W*g +: SEG_W])
    );
  end

endmodule
